// File: rtl/link_supervisor_100m.sv
// rtl/link_supervisor_100m.sv - link bring-up supervisor above the frame synchronizer
// Sequences acquire/lock/holdover/resync from per-frame status pulses and keeps link statistics.
module link_supervisor_100m #(
  parameter int LOCK_FRAMES    = 4,
  parameter int ERR_LIMIT      = 8,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int RESYNC_CYCLES  = 64,
  parameter int CNT_W          = 16
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             data_valid,
  input  logic             frame_error,
  input  logic             sync_lost,
  input  logic             stats_clr,
  output logic             link_up,
  output logic             resync_req,
  output logic [2:0]       link_state,
  output logic             link_change,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] crc_err_cnt,
  output logic [CNT_W-1:0] disc_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RS_W = $clog2(RESYNC_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RS_W-1:0] RS_LAST   = RS_W'(RESYNC_CYCLES - 1);
  localparam logic [3:0]      LOCK_RUN  = 4'(LOCK_FRAMES);
  localparam logic [3:0]      ERR_RUN   = 4'(ERR_LIMIT);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ACQUIRE  = 3'd1,
    ST_LOCKED   = 3'd2,
    ST_HOLDOVER = 3'd3,
    ST_RESYNC   = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [3:0]      good_run, good_run_nxt;
  logic [3:0]      err_run, err_run_nxt;
  logic [WD_W-1:0] wd_cnt, wd_cnt_nxt;
  logic [RS_W-1:0] rs_cnt, rs_cnt_nxt;
  logic            frame_evt, wd_expired, clean_good, up_nxt, counting, loss_evt;

  assign frame_evt  = data_valid | frame_error;
  assign wd_expired = (wd_cnt == WD_LAST) && !frame_evt;
  assign clean_good = data_valid && !frame_error && !sync_lost;
  assign link_state = state;

  always_comb begin
    state_nxt    = state;
    good_run_nxt = good_run;
    err_run_nxt  = err_run;
    rs_cnt_nxt   = '0;
    case (state)
      ST_IDLE: begin
        if (enable) state_nxt = ST_ACQUIRE;
      end
      ST_ACQUIRE: begin
        if (frame_error)                   good_run_nxt = 4'd0;
        else if (data_valid && sync_lost)  good_run_nxt = 4'd1;
        else if (data_valid)               good_run_nxt = good_run + 4'd1;
        else if (sync_lost)                good_run_nxt = 4'd0;
        if (good_run_nxt == LOCK_RUN)      state_nxt = ST_LOCKED;
        else if (wd_expired)               state_nxt = ST_RESYNC;
      end
      ST_LOCKED: begin
        if (frame_error)                   err_run_nxt = err_run + 4'd1;
        else if (data_valid)               err_run_nxt = 4'd0;
        if (err_run_nxt == ERR_RUN)        state_nxt = ST_RESYNC;
        else if (sync_lost || wd_expired)  state_nxt = ST_HOLDOVER;
      end
      ST_HOLDOVER: begin
        if (frame_error)                   err_run_nxt = err_run + 4'd1;
        else if (data_valid)               err_run_nxt = 4'd0;
        if (err_run_nxt == ERR_RUN)        state_nxt = ST_RESYNC;
        else if (sync_lost || wd_expired)  state_nxt = ST_RESYNC;
        else if (clean_good)               state_nxt = ST_LOCKED;
      end
      ST_RESYNC: begin
        if (rs_cnt == RS_LAST) state_nxt = ST_ACQUIRE;
        else                   rs_cnt_nxt = rs_cnt + 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (!enable) state_nxt = ST_IDLE;
    // err_run carries across LOCKED->HOLDOVER so an error burst spanning both still trips RESYNC
    if (state_nxt != state && state_nxt != ST_HOLDOVER) begin
      good_run_nxt = 4'd0;
      err_run_nxt  = 4'd0;
    end
  end

  always_comb begin
    wd_cnt_nxt = wd_cnt + 1'b1;
    if (state_nxt != state || frame_evt || state == ST_IDLE || state == ST_RESYNC)
      wd_cnt_nxt = '0;
  end

  assign up_nxt   = (state_nxt == ST_LOCKED) || (state_nxt == ST_HOLDOVER);
  assign counting = (state != ST_IDLE);
  assign loss_evt = (state_nxt == ST_RESYNC) &&
                    (state == ST_LOCKED || state == ST_HOLDOVER);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_sys) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      good_run    <= 4'd0;
      err_run     <= 4'd0;
      wd_cnt      <= '0;
      rs_cnt      <= '0;
      link_up     <= 1'b0;
      resync_req  <= 1'b0;
      link_change <= 1'b0;
    end else begin
      state       <= state_nxt;
      good_run    <= good_run_nxt;
      err_run     <= err_run_nxt;
      wd_cnt      <= wd_cnt_nxt;
      rs_cnt      <= rs_cnt_nxt;
      link_up     <= up_nxt;
      resync_req  <= (state_nxt == ST_RESYNC);
      link_change <= (up_nxt != link_up);
    end
  end

  // stats_clr takes precedence over any increment landing in the same cycle
  always_ff @(posedge clk_sys) begin
    if (!rst_n || stats_clr) begin
      good_cnt    <= '0;
      crc_err_cnt <= '0;
      disc_cnt    <= '0;
      loss_cnt    <= '0;
    end else begin
      if (counting && data_valid)  good_cnt    <= sat_inc(good_cnt);
      if (counting && frame_error) crc_err_cnt <= sat_inc(crc_err_cnt);
      if (counting && sync_lost)   disc_cnt    <= sat_inc(disc_cnt);
      if (loss_evt)                loss_cnt    <= sat_inc(loss_cnt);
    end
  end

endmodule

// File: tb/tb_link_supervisor_100m.sv
// tb/tb_link_supervisor_100m.sv - directed self-checking bench for link_supervisor_100m
// A second CNT_W=4 instance shares the stimulus to reach counter saturation quickly.
module tb_link_supervisor_100m;

  logic        clk_sys = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        data_valid = 1'b0;
  logic        frame_error = 1'b0;
  logic        sync_lost = 1'b0;
  logic        stats_clr = 1'b0;

  logic        link_up, resync_req, link_change;
  logic [2:0]  link_state;
  logic [15:0] good_cnt, crc_err_cnt, disc_cnt, loss_cnt;

  logic        s_link_up, s_resync_req, s_link_change;
  logic [2:0]  s_link_state;
  logic [3:0]  s_good_cnt, s_crc_err_cnt, s_disc_cnt, s_loss_cnt;

  int checks = 0;
  int failures = 0;
  int n;

  always #5 clk_sys = ~clk_sys;

  link_supervisor_100m dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .enable(enable), .data_valid(data_valid),
    .frame_error(frame_error), .sync_lost(sync_lost), .stats_clr(stats_clr),
    .link_up(link_up), .resync_req(resync_req), .link_state(link_state),
    .link_change(link_change), .good_cnt(good_cnt), .crc_err_cnt(crc_err_cnt),
    .disc_cnt(disc_cnt), .loss_cnt(loss_cnt)
  );

  link_supervisor_100m #(.CNT_W(4)) dut_sat (
    .clk_sys(clk_sys), .rst_n(rst_n), .enable(enable), .data_valid(data_valid),
    .frame_error(frame_error), .sync_lost(sync_lost), .stats_clr(stats_clr),
    .link_up(s_link_up), .resync_req(s_resync_req), .link_state(s_link_state),
    .link_change(s_link_change), .good_cnt(s_good_cnt), .crc_err_cnt(s_crc_err_cnt),
    .disc_cnt(s_disc_cnt), .loss_cnt(s_loss_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int cycles);
    repeat (cycles) @(posedge clk_sys);
    #1;
  endtask

  task automatic ev(input logic dv, input logic fe, input logic sl);
    data_valid = dv; frame_error = fe; sync_lost = sl;
    tick(1);
    data_valid = 1'b0; frame_error = 1'b0; sync_lost = 1'b0;
  endtask

  initial begin
    // reset state
    tick(3);
    chk("rst_state", link_state, 0);
    chk("rst_link_up", link_up, 0);
    chk("rst_resync", resync_req, 0);
    chk("rst_change", link_change, 0);
    chk("rst_good", good_cnt, 0);
    rst_n = 1'b1;
    tick(1);
    chk("idle_hold", link_state, 0);
    enable = 1'b1;
    tick(1);
    chk("acquire_entry", link_state, 1);

    // bring-up: 4 clean frames 100 cycles apart
    for (int i = 0; i < 4; i++) begin
      tick(99);
      ev(1, 0, 0);
      if (i == 2) chk("acq_after3", link_state, 1);
    end
    chk("lock_state", link_state, 2);
    chk("lock_up", link_up, 1);
    chk("lock_change", link_change, 1);
    tick(1);
    chk("lock_change_end", link_change, 0);
    chk("lock_good", good_cnt, 4);

    // 7 errors then a good frame keep LOCKED
    for (int i = 0; i < 7; i++) ev(0, 1, 0);
    chk("err7_locked", link_state, 2);
    ev(1, 0, 0);
    chk("err7_good_locked", link_state, 2);

    // 8 consecutive errors force RESYNC
    for (int i = 0; i < 8; i++) begin
      ev(0, 1, 0);
      if (i == 6) chk("err_run7", link_state, 2);
    end
    chk("resync_state", link_state, 4);
    chk("resync_req_hi", resync_req, 1);
    chk("resync_up", link_up, 0);
    chk("resync_change", link_change, 1);
    chk("loss1", loss_cnt, 1);
    chk("crc15", crc_err_cnt, 15);
    n = 0;
    while (resync_req && n < 200) begin
      n++;
      tick(1);
    end
    chk("resync_len", n, 64);
    chk("resync_to_acq", link_state, 1);

    // ACQUIRE run counting with error and discontinuous frame
    for (int i = 0; i < 3; i++) ev(1, 0, 0);
    ev(0, 1, 0);
    for (int i = 0; i < 3; i++) ev(1, 0, 0);
    ev(1, 0, 1);
    chk("acq_disc_stay", link_state, 1);
    chk("acq_crc", crc_err_cnt, 16);
    chk("acq_disc", disc_cnt, 1);
    ev(1, 0, 0);
    ev(1, 0, 0);
    chk("acq_run3", link_state, 1);
    ev(1, 0, 0);
    chk("acq_relock", link_state, 2);
    chk("acq_good", good_cnt, 15);
    chk("sat_good15", s_good_cnt, 15);
    chk("sat_crc", s_crc_err_cnt, 15);

    // watchdog: LOCKED -> HOLDOVER -> LOCKED
    tick(4095);
    chk("wd_locked_hold", link_state, 2);
    tick(1);
    chk("wd_holdover", link_state, 3);
    chk("hold_up", link_up, 1);
    chk("hold_change", link_change, 0);
    ev(1, 0, 0);
    chk("hold_relock", link_state, 2);
    chk("relock_change", link_change, 0);
    chk("good16", good_cnt, 16);
    chk("sat_good_hold", s_good_cnt, 15);

    // watchdog: LOCKED -> HOLDOVER -> RESYNC
    tick(4096);
    chk("wd_holdover2", link_state, 3);
    tick(4095);
    chk("wd_hold_stay", link_state, 3);
    tick(1);
    chk("wd_resync", link_state, 4);
    chk("loss2", loss_cnt, 2);
    chk("wd_resync_up", link_up, 0);

    // enable dropped mid-RESYNC
    tick(10);
    chk("mid_resync", resync_req, 1);
    enable = 1'b0;
    tick(1);
    chk("en_drop_state", link_state, 0);
    chk("en_drop_req", resync_req, 0);
    chk("en_drop_loss", loss_cnt, 2);

    // stats_clr beats a coincident data_valid
    enable = 1'b1;
    tick(1);
    chk("reacq", link_state, 1);
    stats_clr = 1'b1;
    ev(1, 0, 0);
    stats_clr = 1'b0;
    chk("clr_good", good_cnt, 0);
    chk("clr_crc", crc_err_cnt, 0);
    chk("clr_loss", loss_cnt, 0);
    chk("clr_sat_good", s_good_cnt, 0);

    // rst_n asserted mid-LOCKED
    for (int i = 0; i < 4; i++) ev(1, 0, 0);
    chk("lock2", link_state, 2);
    chk("lock2_good", good_cnt, 4);
    rst_n = 1'b0;
    tick(1);
    chk("rst_mid_state", link_state, 0);
    chk("rst_mid_up", link_up, 0);
    chk("rst_mid_good", good_cnt, 0);
    rst_n = 1'b1;
    tick(1);
    chk("post_rst_acq", link_state, 1);

    // enable drop from LOCKED pulses link_change
    for (int i = 0; i < 4; i++) ev(1, 0, 0);
    chk("lock3", link_state, 2);
    enable = 1'b0;
    tick(1);
    chk("drop_lock_state", link_state, 0);
    chk("drop_lock_up", link_up, 0);
    chk("drop_lock_change", link_change, 1);

    // ACQUIRE watchdog expiry goes to RESYNC without counting a loss
    enable = 1'b1;
    tick(1);
    chk("acq4", link_state, 1);
    tick(4095);
    chk("acq_wd_hold", link_state, 1);
    tick(1);
    chk("acq_wd_resync", link_state, 4);
    chk("acq_wd_loss", loss_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/link_supervisor_100m.md
Name: link_supervisor_100m

Overview:
Link-level controller sitting above the 56-bit frame synchronizer on the 100 MHz system clock. Consumes its per-frame status pulses (data_valid, frame_error, sync_lost) and sequences link bring-up: acquisition, lock qualification, holdover, forced resync. Drives a resync request that flushes the synchronizer/CDR path, a qualified link_up to downstream consumers, and saturating statistics counters for software.

Parameters:
LOCK_FRAMES, 4, consecutive clean frames required in ACQUIRE to declare lock (1..15)
ERR_LIMIT, 8, consecutive CRC errors in LOCKED/HOLDOVER that force RESYNC (1..15)
TIMEOUT_CYCLES, 4096, clk_sys cycles without any frame event before watchdog expiry (>=2)
RESYNC_CYCLES, 64, length of the resync_req assertion (>=1)
CNT_W, 16, statistics counter width

Ports:
clk_sys  input  1  100 MHz system clock
rst_n  input  1  synchronous active-low reset
enable  input  1  level; 0 forces IDLE
data_valid  input  1  1-cycle pulse, good-CRC frame from synchronizer
frame_error  input  1  1-cycle pulse, CRC error
sync_lost  input  1  1-cycle pulse, counter discontinuity or sync drop
stats_clr  input  1  1-cycle pulse, clears all statistics counters
link_up  output  1  high in LOCKED and HOLDOVER
resync_req  output  1  high while in RESYNC
link_state  output  3  IDLE=0, ACQUIRE=1, LOCKED=2, HOLDOVER=3, RESYNC=4
link_change  output  1  1-cycle pulse when link_up toggles
good_cnt  output  CNT_W  frames with data_valid
crc_err_cnt  output  CNT_W  frame_error pulses
disc_cnt  output  CNT_W  sync_lost pulses
loss_cnt  output  CNT_W  transitions into RESYNC from LOCKED/HOLDOVER

Behaviour:
- Reset (rst_n=0 at clk_sys edge): state IDLE, all outputs 0, all internal counters 0. Reset mid-operation aborts RESYNC immediately (resync_req low next cycle).
- All outputs registered; link_up, resync_req, link_state reflect the state register (same cycle state changes). Events take effect 1 cycle after the pulse.
- Event priority in a cycle: frame_error over data_valid; data_valid+sync_lost together = "discontinuous good frame".
- Watchdog: counts cycles, reset to 0 by data_valid or frame_error and on every state entry; expiry when count reaches TIMEOUT_CYCLES-1 with no event that cycle.
- IDLE: enable=1 -> ACQUIRE. enable=0 in any state -> IDLE next cycle (overrides everything, including RESYNC).
- ACQUIRE: good_run counter. Clean data_valid -> good_run+1; data_valid+sync_lost -> good_run=1; frame_error or lone sync_lost -> good_run=0. good_run reaching LOCK_FRAMES -> LOCKED. Watchdog expiry -> RESYNC.
- LOCKED: err_run counter. frame_error -> err_run+1; any data_valid -> err_run=0. err_run reaching ERR_LIMIT -> RESYNC. sync_lost (alone or with data_valid) -> HOLDOVER. Watchdog expiry -> HOLDOVER.
- HOLDOVER: link_up stays 1. Clean data_valid -> LOCKED. frame_error counts err_run as in LOCKED; ERR_LIMIT -> RESYNC. Watchdog expiry -> RESYNC. sync_lost here -> RESYNC.
- RESYNC: resync_req=1 for exactly RESYNC_CYCLES cycles, frame events ignored for state; then ACQUIRE with good_run=0, err_run=0.
- link_change pulses the cycle link_up changes value (including enable drop from LOCKED).
- Statistics: increment on each respective pulse in every state except IDLE; saturate at all-ones; stats_clr sets all four to 0 and wins over same-cycle increment. loss_cnt increments on entry to RESYNC from LOCKED/HOLDOVER only.

Test Plan:
- Reset, enable=1, 4 clean data_valid pulses 100 cycles apart -> link_state 1 then 2 on cycle after 4th pulse, link_up=1, link_change 1-cycle pulse, good_cnt=4.
- ACQUIRE: 3 good, 1 frame_error, 3 good, 1 data_valid+sync_lost -> stays ACQUIRE (good_run=1), crc_err_cnt=1, disc_cnt=1; 3 more good -> LOCKED.
- LOCKED: 8 consecutive frame_error -> RESYNC, resync_req high exactly 64 cycles, link_up falls, loss_cnt=1, then ACQUIRE; 7 errors + 1 good -> stays LOCKED.
- LOCKED: no events 4095 cycles -> HOLDOVER (link_up stays 1); clean data_valid -> LOCKED; instead 4095 more idle cycles -> RESYNC.
- good_cnt forced to 0xFFFF by 65535+ pulses (or CNT_W=4 build) -> saturates; stats_clr coincident with data_valid -> 0.
- enable dropped mid-RESYNC and rst_n asserted mid-LOCKED -> IDLE next cycle, resync_req=0, link_up=0, counters per reset rules.
